// File: rtl/glitch_pulse_if.sv
// glitch_pulse_if: control/config/status bundle between a sequencer and glitch_pulse.
//   master: drives arm, abort, trigger and the delay/width/gap/count config;
//           observes glitch, busy and done.
//   slave : the glitch_pulse block itself.
interface glitch_pulse_if #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PC_W  = 4
);
    logic             arm;
    logic             abort;
    logic             trigger;
    logic [CNT_W-1:0] delay;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] gap;
    logic [PC_W-1:0]  count;
    logic             glitch;
    logic             busy;
    logic             done;

    modport master (
        output arm, abort, trigger, delay, width, gap, count,
        input  glitch, busy, done
    );

    modport slave (
        input  arm, abort, trigger, delay, width, gap, count,
        output glitch, busy, done
    );
endinterface

// File: rtl/glitch_pulse.sv
// glitch_pulse: consumer end of the detector trigger line.
// Once armed it waits for a trigger, counts a programmable delay, then emits a
// train of glitch pulses with programmable width, gap and count.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - glitch_pulse_if.slave: arm/abort/trigger, delay/width/gap/count config
//          (latched at arm), glitch/busy/done registered outputs.
// All outputs are registered from the current state, so each output follows
// its state by one edge; abort and rst force them idle on the sampling edge.
module glitch_pulse #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned PC_W          = 4,
    parameter bit          GLITCH_ACTIVE = 1'b1
) (
    input logic           clk,
    input logic           rst,
    glitch_pulse_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitLow,
        StArmed,
        StDelay,
        StPulse,
        StGap,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [PC_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PC_W-1:0]  pulses_q, pulses_d;
    logic [PC_W-1:0]  pulses_dec;
    logic             glitch_q, glitch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        width_d    = width_q;
        gap_d      = gap_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        pulses_d   = pulses_q;
        pulses_dec = (pulses_q == '0) ? '0 : pulses_q - 1'b1;

        if (bus.abort) begin
            state_d  = StIdle;
            cnt_d    = '0;
            pulses_d = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.arm) begin
                        // Zero width/gap/count are promoted to one.
                        delay_d = bus.delay;
                        width_d = (bus.width == '0) ? CNT_W'(1) : bus.width;
                        gap_d   = (bus.gap == '0) ? CNT_W'(1) : bus.gap;
                        count_d = (bus.count == '0) ? PC_W'(1) : bus.count;
                        state_d = StWaitLow;
                    end
                end
                StWaitLow: begin
                    // A trigger already high at arming must fall before it counts.
                    if (!bus.trigger) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    if (bus.trigger) begin
                        pulses_d = count_q;
                        if (delay_q != '0) begin
                            state_d = StDelay;
                            cnt_d   = delay_q;
                        end else begin
                            state_d = StPulse;
                            cnt_d   = width_q;
                        end
                    end else if (!bus.arm) begin
                        state_d = StIdle;
                    end
                end
                StDelay: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = StPulse;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StPulse: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        pulses_d = pulses_dec;
                        if (pulses_dec != '0) begin
                            state_d = StGap;
                            cnt_d   = gap_q;
                        end else begin
                            state_d = StDone;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = StPulse;
                        cnt_d   = width_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (!bus.arm) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs decode the current state; abort knocks them idle on the same edge.
    always_comb begin
        glitch_d = (!bus.abort && state_q == StPulse) ? GLITCH_ACTIVE : ~GLITCH_ACTIVE;
        busy_d   = !bus.abort &&
                   (state_q == StDelay || state_q == StPulse || state_q == StGap);
        done_d   = !bus.abort && (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            delay_q  <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            pulses_q <= '0;
            glitch_q <= ~GLITCH_ACTIVE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            delay_q  <= delay_d;
            width_q  <= width_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            pulses_q <= pulses_d;
            glitch_q <= glitch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.glitch = glitch_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule
